// File: rtl/int_to_float_spec.sv
// int_to_float_spec: converts a 32-bit two's-complement integer to an
// IEEE-754 single-precision float, round-to-nearest-even.
// Handshake is stb/ack on both sides. Normalisation shifts one bit per
// cycle, so latency depends on the operand's leading-zero count.
module int_to_float_spec (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  typedef enum logic [2:0] {
    GET_A     = 3'd0,
    CONVERT   = 3'd1,
    NORMALISE = 3'd2,
    ROUND     = 3'd3,
    PACK      = 3'd4,
    PUT_Z     = 3'd5
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [31:0] a_r;
  logic [31:0] mag_r;
  logic        sign_r;
  logic [7:0]  exp_r;
  logic [23:0] mant_r;
  logic        zero_r;
  logic        ack_r;
  logic        stb_r;
  logic [31:0] z_r;
  logic        ack_nxt_s;
  logic        stb_nxt_s;
  logic        round_up_s;
  logic [24:0] mant_inc_s;

  assign input_a_ack  = ack_r;
  assign output_z_stb = stb_r;
  assign output_z     = z_r;

  // Rounding decision on the normalised magnitude: guard, round and sticky bits.
  always_comb begin
    round_up_s = mag_r[7] && (mag_r[6] || (|mag_r[5:0]) || mag_r[8]);
    mant_inc_s = {1'b0, mag_r[31:8]} + 25'd1;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= GET_A;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic. A zero operand passes through PACK so that it
  // reaches PUT_Z two cycles after acceptance.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      GET_A: begin
        if (ack_r && input_a_stb) state_nxt_s = CONVERT;
        else                      state_nxt_s = GET_A;
      end
      CONVERT: begin
        if (a_r == 32'd0) state_nxt_s = PACK;
        else              state_nxt_s = NORMALISE;
      end
      NORMALISE: begin
        if (mag_r[31]) state_nxt_s = ROUND;
        else           state_nxt_s = NORMALISE;
      end
      ROUND:   state_nxt_s = PACK;
      PACK:    state_nxt_s = PUT_Z;
      PUT_Z: begin
        if (output_z_ack) state_nxt_s = GET_A;
        else              state_nxt_s = PUT_Z;
      end
      default: state_nxt_s = GET_A;
    endcase
  end

  // Next values of the registered handshake outputs.
  always_comb begin
    ack_nxt_s = 1'b0;
    stb_nxt_s = 1'b0;
    case (state_r)
      GET_A: begin
        ack_nxt_s = !(ack_r && input_a_stb);
        stb_nxt_s = 1'b0;
      end
      PACK: begin
        ack_nxt_s = 1'b0;
        stb_nxt_s = 1'b1;
      end
      PUT_Z: begin
        ack_nxt_s = output_z_ack;
        stb_nxt_s = !output_z_ack;
      end
      default: begin
        ack_nxt_s = 1'b0;
        stb_nxt_s = 1'b0;
      end
    endcase
  end

  // Handshake output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_r <= 1'b0;
      stb_r <= 1'b0;
    end else begin
      ack_r <= ack_nxt_s;
      stb_r <= stb_nxt_s;
    end
  end

  // Datapath: capture, magnitude, normalise, round and pack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_r    <= 32'd0;
      mag_r  <= 32'd0;
      sign_r <= 1'b0;
      exp_r  <= 8'd0;
      mant_r <= 24'd0;
      zero_r <= 1'b0;
      z_r    <= 32'd0;
    end else begin
      case (state_r)
        GET_A: begin
          if (ack_r && input_a_stb) a_r <= input_a;
        end
        CONVERT: begin
          zero_r <= (a_r == 32'd0);
          if (a_r == 32'd0) begin
            z_r <= 32'd0;
          end else begin
            sign_r <= a_r[31];
            mag_r  <= a_r[31] ? (~a_r + 32'd1) : a_r;
            exp_r  <= 8'd31;
          end
        end
        NORMALISE: begin
          if (!mag_r[31]) begin
            mag_r <= mag_r << 1;
            exp_r <= exp_r - 8'd1;
          end
        end
        ROUND: begin
          if (round_up_s) begin
            if (mant_inc_s[24]) begin
              mant_r <= 24'h800000;
              exp_r  <= exp_r + 8'd1;
            end else begin
              mant_r <= mant_inc_s[23:0];
            end
          end else begin
            mant_r <= mag_r[31:8];
          end
        end
        PACK: begin
          if (zero_r) z_r <= 32'd0;
          else        z_r <= {sign_r, exp_r + 8'd127, mant_r[22:0]};
        end
        default: begin
          z_r <= z_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_to_float_spec.sv
// Self-checking bench for int_to_float_spec: known values, rounding cases,
// backpressure, reset mid-conversion and a randomised back-to-back stream.
module tb_int_to_float_spec;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] input_a = 32'd0;
  logic        input_a_stb = 1'b0;
  logic        input_a_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack = 1'b0;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  int_to_float_spec dut (
    .clk          (clk),
    .rst          (rst),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference conversion: locate the MSB, then round the discarded bits.
  function automatic logic [31:0] ref_i2f(input logic [31:0] v);
    logic [63:0] mag, mant, rem, half;
    int p, sh;
    logic s;
    if (v == 32'd0) return 32'd0;
    s = v[31];
    mag = {32'd0, v};
    if (s) mag = 64'h1_0000_0000 - mag;
    p = 0;
    for (int i = 0; i < 64; i++) if (mag[i]) p = i;
    if (p <= 23) begin
      mant = mag << (23 - p);
    end else begin
      sh = p - 23;
      mant = mag >> sh;
      rem = mag & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && mant[0])) mant = mant + 64'd1;
      if (mant == (64'd1 << 24)) begin
        mant = mant >> 1;
        p = p + 1;
      end
    end
    return {s, 8'(p + 127), mant[22:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] v, output bit ok);
    logic pre;
    input_a = v;
    input_a_stb = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      pre = input_a_ack;
      tick();
      if (pre) ok = 1'b1;
    end
    input_a_stb = 1'b0;
  endtask

  task automatic wait_stb(output int cyc, output bit ok);
    cyc = 0;
    while (!output_z_stb && cyc < 200) begin
      tick();
      cyc++;
    end
    ok = output_z_stb;
  endtask

  task automatic do_ack();
    output_z_ack = 1'b1;
    tick();
    output_z_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    input_a = 32'd123;
    input_a_stb = 1'b1;
    repeat (3) tick();
    checks++; if (input_a_ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", input_a_ack); end
    checks++; if (output_z_stb !== 1'b0) begin failures++; $display("FAIL reset_stb got=%b exp=0", output_z_stb); end
    checks++; if (output_z !== 32'd0) begin failures++; $display("FAIL reset_z got=%h exp=0", output_z); end
    rst = 1'b1;
    input_a_stb = 1'b0;
    #1;
    checks++; if (input_a_ack !== 1'b0) begin failures++; $display("FAIL release_ack_before_edge got=%b exp=0", input_a_ack); end
    tick();
    checks++; if (input_a_ack !== 1'b1) begin failures++; $display("FAIL release_ack_after_edge got=%b exp=1", input_a_ack); end
    rst = 1'b0;
    #1;
    checks++; if (input_a_ack !== 1'b0) begin failures++; $display("FAIL async_reset_ack got=%b exp=0", input_a_ack); end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [31:0] tv[4]  = '{32'h00000001, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    logic [31:0] tz[4]  = '{32'h3F800000, 32'hBF800000, 32'h00000000, 32'hCF000000};
    int          tl[4]  = '{35, 35, 2, 4};
    logic [31:0] got;
    int lat;
    bit ok;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(tz[i]);
      send(tv[i], ok);
      checks++; if (!ok) begin failures++; $display("FAIL basic_accept[%0d] got=timeout exp=accept", i); end
      wait_stb(lat, ok);
      got = exp_q.pop_front();
      checks++;
      if (!ok) begin
        failures++; $display("FAIL basic_stb[%0d] got=timeout exp=stb", i);
      end else begin
        if (output_z !== got) begin failures++; $display("FAIL basic_z[%0d] got=%h exp=%h", i, output_z, got); end
        checks++; if (lat != tl[i]) begin failures++; $display("FAIL basic_latency[%0d] got=%0d exp=%0d", i, lat, tl[i]); end
      end
      do_ack();
      checks++; if (output_z_stb !== 1'b0) begin failures++; $display("FAIL basic_stb_drop[%0d] got=%b exp=0", i, output_z_stb); end
    end
  endtask

  task automatic test_rounding();
    logic [31:0] tv[4] = '{32'h01000001, 32'h01000003, 32'h7FFFFFFF, 32'h00FFFFFF};
    logic [31:0] tz[4] = '{32'h4B800000, 32'h4B800002, 32'h4F000000, 32'h4B7FFFFF};
    int          tl[4] = '{11, 11, 5, 12};
    logic [31:0] got;
    int lat;
    bit ok;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(tz[i]);
      send(tv[i], ok);
      checks++; if (!ok) begin failures++; $display("FAIL round_accept[%0d] got=timeout exp=accept", i); end
      wait_stb(lat, ok);
      got = exp_q.pop_front();
      checks++;
      if (!ok) begin
        failures++; $display("FAIL round_stb[%0d] got=timeout exp=stb", i);
      end else begin
        if (output_z !== got) begin failures++; $display("FAIL round_z[%0d] got=%h exp=%h", i, output_z, got); end
        checks++; if (lat != tl[i]) begin failures++; $display("FAIL round_latency[%0d] got=%0d exp=%0d", i, lat, tl[i]); end
      end
      do_ack();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] got, hold;
    int lat;
    bit ok;
    exp_q.push_back(32'h40400000);
    send(32'd3, ok);
    wait_stb(lat, ok);
    got = exp_q.pop_front();
    checks++; if (!ok || output_z !== got) begin failures++; $display("FAIL bp_first_z got=%h exp=%h", output_z, got); end
    hold = output_z;
    input_a = 32'h12345678;
    input_a_stb = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (output_z !== hold || output_z_stb !== 1'b1 || input_a_ack !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d] got z=%h stb=%b ack=%b exp z=%h stb=1 ack=0", i, output_z, output_z_stb, input_a_ack, hold);
      end
    end
    output_z_ack = 1'b1;
    tick();
    output_z_ack = 1'b0;
    checks++;
    if (output_z_stb !== 1'b0 || input_a_ack !== 1'b1) begin
      failures++; $display("FAIL bp_release got stb=%b ack=%b exp stb=0 ack=1", output_z_stb, input_a_ack);
    end
    exp_q.push_back(ref_i2f(32'h12345678));
    tick();
    input_a_stb = 1'b0;
    checks++; if (input_a_ack !== 1'b0) begin failures++; $display("FAIL bp_next_accept got ack=%b exp=0", input_a_ack); end
    wait_stb(lat, ok);
    got = exp_q.pop_front();
    checks++; if (!ok || output_z !== got) begin failures++; $display("FAIL bp_second_z got=%h exp=%h", output_z, got); end
    do_ack();
  endtask

  task automatic test_reset_mid();
    logic [31:0] got;
    int lat;
    bit ok, seen;
    send(32'd5, ok);
    repeat (5) tick();
    rst = 1'b0;
    #1;
    checks++;
    if (output_z_stb !== 1'b0 || input_a_ack !== 1'b0 || output_z !== 32'd0) begin
      failures++; $display("FAIL midreset_clear got stb=%b ack=%b z=%h exp 0/0/0", output_z_stb, input_a_ack, output_z);
    end
    tick();
    tick();
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (output_z_stb) seen = 1'b1;
    end
    checks++; if (seen) begin failures++; $display("FAIL midreset_no_output got stb=1 exp stb=0"); end
    exp_q.push_back(32'h40E00000);
    send(32'd7, ok);
    wait_stb(lat, ok);
    got = exp_q.pop_front();
    checks++; if (!ok || output_z !== got) begin failures++; $display("FAIL midreset_seven got=%h exp=%h", output_z, got); end
    do_ack();
  endtask

  task automatic test_back_to_back();
    logic [31:0] v, got;
    int cyc, d;
    bit ok;
    for (int n = 0; n < 1000; n++) begin
      for (int g = $urandom_range(0, 3); g > 0; g--) begin
        output_z_ack = 1'($urandom_range(0, 1));
        tick();
      end
      output_z_ack = 1'b0;
      case ($urandom_range(0, 2))
        0: v = $urandom;
        1: v = $urandom >> $urandom_range(0, 31);
        default: v = -($urandom >> $urandom_range(0, 31));
      endcase
      exp_q.push_back(ref_i2f(v));
      send(v, ok);
      cyc = 0;
      while (!output_z_stb && cyc < 200) begin
        input_a = $urandom;
        input_a_stb = 1'($urandom_range(0, 1));
        output_z_ack = 1'($urandom_range(0, 1));
        tick();
        cyc++;
      end
      input_a_stb = 1'b0;
      output_z_ack = 1'b0;
      got = exp_q.pop_front();
      checks++;
      if (!ok || !output_z_stb) begin
        failures++; $display("FAIL b2b_timeout[%0d] input=%h", n, v);
      end else if (output_z !== got) begin
        failures++; $display("FAIL b2b_z[%0d] input=%h got=%h exp=%h", n, v, output_z, got);
      end
      d = $urandom_range(0, 2);
      repeat (d) tick();
      do_ack();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
